mem_port_arbiter: RTL and testbench

Shares the single unified synchronous memory port between the pipeline's instruction-fetch stage and its load/store stage. The block sits between the core's fetch/memory stages and the memory macro. Each cycle it grants at most one requester and drives the memory port. It then routes the one-cycle-latency read response back to whichever requester issued the read. Data accesses have fixed priority; an optional starvation guard bounds how long fetch can be held off.

---
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 102 ++++++++++
 tb/tb_mem_port_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Shared memory-port bundle between fetch, load/store and the memory macro.
// slave = arbiter side, master = core/memory side.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic            if_gnt;
  logic            if_rvalid;
  logic [DW-1:0]   if_rdata;
  logic            dm_req;
  logic            dm_we;
  logic [AW-1:0]   dm_addr;
  logic [DW-1:0]   dm_wdata;
  logic [DW/8-1:0] dm_wstrb;
  logic            dm_gnt;
  logic            dm_rvalid;
  logic [DW-1:0]   dm_rdata;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_wstrb;
  logic [DW-1:0]   mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr,
    input  dm_wdata, dm_wstrb,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_en, mem_we, mem_addr,
    output mem_wdata, mem_wstrb
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr,
    output dm_wdata, dm_wstrb,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_en, mem_we, mem_addr,
    input  mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch vs load/store arbiter for one synchronous memory port.
// Define ARB_STARVE_GUARD_EN to build the fetch starvation guard.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    RSP_NONE,
    RSP_IF,
    RSP_DM
  } rsp_e;

  if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_chk
    $error("STARVE_MAX out of range");
  end

  rsp_e            rsp_q;
  logic            force_if;
  logic            if_gnt;
  logic            dm_gnt;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            we;

`ifdef ARB_STARVE_GUARD_EN
  logic [7:0] starve_q;

  assign force_if = (starve_q == 8'(STARVE_MAX));

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else if (if_gnt) begin
      starve_q <= '0;
    end else if (bus.if_req) begin
      starve_q <= starve_q + 8'd1;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  // A forced fetch only steals the slot when fetch is actually asking.
  assign dm_gnt = ~reset & bus.dm_req
                & ~(force_if & bus.if_req);
  assign if_gnt = ~reset & bus.if_req & ~dm_gnt;

  always_comb begin
    addr  = '0;
    wdata = '0;
    wstrb = '0;
    we    = 1'b0;
    unique case (1'b1)
      dm_gnt: begin
        addr  = bus.dm_addr;
        wdata = bus.dm_wdata;
        wstrb = bus.dm_wstrb;
        we    = bus.dm_we;
      end
      if_gnt: begin
        addr  = bus.if_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_q <= RSP_NONE;
    end else if (if_gnt) begin
      rsp_q <= RSP_IF;
    end else if (dm_gnt && !bus.dm_we) begin
      rsp_q <= RSP_DM;
    end else begin
      rsp_q <= RSP_NONE;
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.dm_gnt    = dm_gnt;
  assign bus.mem_en    = if_gnt | dm_gnt;
  assign bus.mem_we    = we;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = wdata;
  assign bus.mem_wstrb = wstrb;

  // Routing depends only on who owned last cycle's read.
  assign bus.if_rvalid = (rsp_q == RSP_IF);
  assign bus.dm_rvalid = (rsp_q == RSP_DM);
  assign bus.if_rdata  = bus.if_rvalid
                       ? bus.mem_rdata : '0;
  assign bus.dm_rdata  = bus.dm_rvalid
                       ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a 1-cycle memory model.
// Expectations follow ARB_STARVE_GUARD_EN when it is defined.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(
    .AW(AW),
    .DW(DW),
    .STARVE_MAX(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [31:0] mem [0:255];
  logic [31:0] rdata_q;
  assign bus.mem_rdata = rdata_q;

  // Junk on idle cycles exposes any ungated rdata path.
  always @(posedge clk) begin
    if (reset) begin
      mem[4]   <= 32'h0051_3093;
      mem[128] <= 32'h1122_3344;
    end
    rdata_q <= 32'hBAD0_BAD0;
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_wstrb[b])
            mem[bus.mem_addr[9:2]][8*b +: 8]
              <= bus.mem_wdata[8*b +: 8];
      end else begin
        rdata_q <= mem[bus.mem_addr[9:2]];
      end
    end
  end

  typedef struct {
    bit          is_dm;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  task automatic push(input bit is_dm,
                      input logic [31:0] d);
    exp_t e;
    e.is_dm = is_dm;
    e.data  = d;
    q.push_back(e);
  endtask

  // Monitor: pops one expectation per response seen.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.if_rvalid || bus.dm_rvalid) begin
        if (q.size() == 0) begin
          chk("unexp_rvalid",
              {30'd0, bus.dm_rvalid, bus.if_rvalid},
              32'd0);
        end else begin
          e = q.pop_front();
          chk("rsp_if_rvalid",
              {31'd0, bus.if_rvalid},
              {31'd0, !e.is_dm});
          chk("rsp_dm_rvalid",
              {31'd0, bus.dm_rvalid},
              {31'd0, e.is_dm});
          chk("rsp_rdata",
              e.is_dm ? bus.dm_rdata : bus.if_rdata,
              e.data);
        end
      end
      if (!bus.if_rvalid)
        chk("if_rdata_idle", bus.if_rdata, 32'd0);
      if (!bus.dm_rvalid)
        chk("dm_rdata_idle", bus.dm_rdata, 32'd0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.dm_req   = 1'b0;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;
    bus.dm_wstrb = '0;
  endtask

  task automatic fetch(input logic [31:0] a);
    bus.if_req  = 1'b1;
    bus.if_addr = a;
  endtask

  task automatic data(input bit we,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [3:0] s);
    bus.dm_req   = 1'b1;
    bus.dm_we    = we;
    bus.dm_addr  = a;
    bus.dm_wdata = d;
    bus.dm_wstrb = s;
  endtask

  task automatic gnts(input string nm,
                      input bit ei, input bit ed);
    chk({nm, "_if_gnt"},
        {31'd0, bus.if_gnt}, {31'd0, ei});
    chk({nm, "_dm_gnt"},
        {31'd0, bus.dm_gnt}, {31'd0, ed});
  endtask

  initial begin
    reset = 1'b1;
    idle();
    fetch(32'h10);
    data(1'b0, 32'h100, '0, '0);
    cyc();
    smp();
    gnts("rst", 1'b0, 1'b0);
    chk("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);

    cyc();
    reset = 1'b0;
    idle();
    smp();
    chk("rst_if_rvalid",
        {31'd0, bus.if_rvalid}, 32'd0);
    chk("rst_dm_rvalid",
        {31'd0, bus.dm_rvalid}, 32'd0);
    chk("idle_mem_addr", bus.mem_addr, 32'd0);

    // Fetch only
    cyc();
    fetch(32'h10);
    smp();
    gnts("f1", 1'b1, 1'b0);
    chk("f1_mem_en", {31'd0, bus.mem_en}, 32'd1);
    chk("f1_mem_addr", bus.mem_addr, 32'h10);
    chk("f1_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("f1_mem_wstrb",
        {28'd0, bus.mem_wstrb}, 32'd0);
    push(1'b0, 32'h0051_3093);
    cyc();
    idle();

    // Store then load
    cyc();
    data(1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF);
    smp();
    gnts("st", 1'b0, 1'b1);
    chk("st_mem_we", {31'd0, bus.mem_we}, 32'd1);
    chk("st_mem_wdata", bus.mem_wdata,
        32'hDEAD_BEEF);
    chk("st_mem_wstrb",
        {28'd0, bus.mem_wstrb}, 32'hF);
    cyc();
    data(1'b0, 32'h100, '0, '0);
    smp();
    gnts("ld", 1'b0, 1'b1);
    chk("ld_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("ld_mem_addr", bus.mem_addr, 32'h100);
    push(1'b1, 32'hDEAD_BEEF);
    cyc();
    idle();

    // Contention: dm first, fetch retried next cycle
    cyc();
    fetch(32'h10);
    data(1'b0, 32'h100, '0, '0);
    smp();
    gnts("ct1", 1'b0, 1'b1);
    chk("ct1_mem_addr", bus.mem_addr, 32'h100);
    push(1'b1, 32'hDEAD_BEEF);
    cyc();
    bus.dm_req = 1'b0;
    smp();
    gnts("ct2", 1'b1, 1'b0);
    chk("ct2_mem_addr", bus.mem_addr, 32'h10);
    push(1'b0, 32'h0051_3093);
    cyc();
    idle();

    // Byte store then readback
    cyc();
    data(1'b1, 32'h200, 32'h0000_AB00, 4'h2);
    smp();
    chk("bs_mem_wstrb",
        {28'd0, bus.mem_wstrb}, 32'h2);
    chk("bs_mem_wdata", bus.mem_wdata,
        32'h0000_AB00);
    cyc();
    data(1'b0, 32'h200, '0, '0);
    smp();
    push(1'b1, 32'h1122_AB44);
    cyc();
    idle();

    // Starvation window
    for (int i = 0; i < 8; i++) begin
      bit ei;
      cyc();
      fetch(32'h10);
      data(1'b0, 32'h100, '0, '0);
      smp();
      ei = GUARD && (i == 4);
      gnts($sformatf("sv%0d", i), ei, !ei);
      if (ei)
        push(1'b0, 32'h0051_3093);
      else
        push(1'b1, 32'hDEAD_BEEF);
    end
    cyc();
    idle();

    // Reset sampled at the end of a fetch grant
    cyc();
    fetch(32'h10);
    smp();
    gnts("mr", 1'b1, 1'b0);
    #1;
    reset = 1'b1;
    cyc();
    data(1'b0, 32'h100, '0, '0);
    smp();
    chk("mr_if_rvalid",
        {31'd0, bus.if_rvalid}, 32'd0);
    gnts("mr_rst", 1'b0, 1'b0);
    chk("mr_mem_en", {31'd0, bus.mem_en}, 32'd0);
    cyc();
    reset = 1'b0;
    bus.dm_req = 1'b0;
    smp();
    gnts("mr_resume", 1'b1, 1'b0);
    push(1'b0, 32'h0051_3093);
    cyc();
    idle();
    repeat (3) cyc();

    chk("sb_drain", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
